rpn_stack_engine: RTL and testbench

//  Parametrised successor to the stack ALU: evaluates a streamed RPN token sequence on an internal stack.

---
 rtl/rpn_pkg.sv | 39 +++
 rtl/seq_signed_mul.sv | 74 +++++++
 rtl/rpn_stack_engine.sv | 212 +++++++++++++++++++++
 tb/tb_rpn_stack_engine.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared definitions for the RPN stack engine.
//   - 3-bit token opcodes (OP_SUB .. OP_NOP)
//   - engine state encoding (ST_ACCEPT, ST_MUL, ST_EMIT)
//   - small opcode classification helpers used by the engine decode
package rpn_pkg;

  localparam logic [2:0] OP_SUB  = 3'b000;
  localparam logic [2:0] OP_DUP  = 3'b001;
  localparam logic [2:0] OP_SWAP = 3'b010;
  localparam logic [2:0] OP_POP  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_MUL    = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  // Number of stack entries an opcode must find before it may execute.
  function automatic logic [1:0] operands_needed(input logic [2:0] op);
    case (op)
      OP_SUB, OP_SWAP, OP_ADD, OP_MUL: operands_needed = 2'd2;
      OP_DUP, OP_POP:                  operands_needed = 2'd1;
      default:                         operands_needed = 2'd0;
    endcase
  endfunction

  // Opcodes that add an entry to the stack (rejected when it is full).
  function automatic logic grows_stack(input logic [2:0] op);
    case (op)
      OP_PUSH, OP_DUP: grows_stack = 1'b1;
      default:         grows_stack = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_signed_mul.sv
// seq_signed_mul: iterative signed multiplier, one partial product per cycle.
//   Multiplies the operand magnitudes by shift-add and restores the sign at
//   the output. Bit 0 of the multiplier is folded in on the start cycle, so
//   done rises exactly N cycles after start.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     load operands a, b and begin (ignored while busy)
//   busy      multiplication in progress (includes the done cycle)
//   done      product and overflow are valid this cycle
//   product   full 2N-bit signed product a*b
//   overflow  product does not fit in N signed bits
module seq_signed_mul #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           overflow
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]   mag_a_s, mag_b_s;
  logic [N-1:0]   mplier_r;
  logic [2*N-1:0] mcand_r, acc_r;
  logic           neg_r, busy_r;
  logic [CW-1:0]  count_r;

  // Operand magnitudes; -2^(N-1) maps to 2^(N-1), which still fits unsigned.
  always_comb begin
    mag_a_s = a[N-1] ? -a : a;
    mag_b_s = b[N-1] ? -b : b;
  end

  // Shift-add iteration: count_r tracks how many multiplier bits are consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      neg_r    <= 1'b0;
      count_r  <= {CW{1'b0}};
      acc_r    <= {(2*N){1'b0}};
      mcand_r  <= {(2*N){1'b0}};
      mplier_r <= {N{1'b0}};
    end else if (start && !busy_r) begin
      busy_r   <= 1'b1;
      neg_r    <= a[N-1] ^ b[N-1];
      count_r  <= CW'(1);
      acc_r    <= mag_a_s[0] ? {{N{1'b0}}, mag_b_s} : {(2*N){1'b0}};
      mcand_r  <= {{(N-1){1'b0}}, mag_b_s, 1'b0};
      mplier_r <= mag_a_s >> 1;
    end else if (busy_r && (count_r != CW'(N))) begin
      acc_r    <= mplier_r[0] ? (acc_r + mcand_r) : acc_r;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      count_r  <= count_r + CW'(1);
    end else begin
      busy_r   <= 1'b0;
    end
  end

  // Sign fix-up and range check of the finished product.
  always_comb begin
    busy     = busy_r;
    done     = busy_r && (count_r == CW'(N));
    product  = neg_r ? -acc_r : acc_r;
    overflow = ~((&product[2*N-1:N-1]) | ~(|product[2*N-1:N-1]));
  end

endmodule

// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: evaluates a streamed RPN token sequence on an internal
//   register stack and emits the top of stack with sticky status flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        token handshake; in_opcode, in_data, in_last
//   out_valid/out_ready      result handshake; out_data, out_overflow, out_error
//   depth                    current stack occupancy
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter int N          = 16,
  parameter int STACK_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_opcode,
  input  logic [N-1:0]                  in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0]                  out_data,
  output logic                          out_overflow,
  output logic                          out_error,
  output logic [$clog2(STACK_SIZE+1)-1:0] depth
);

  localparam int DW = $clog2(STACK_SIZE + 1);
  localparam int IW = (STACK_SIZE > 1) ? $clog2(STACK_SIZE) : 1;

  state_t         state_r, state_nxt_s;
  logic [N-1:0]   stack_r [STACK_SIZE];
  logic [DW-1:0]  depth_r, depth_nxt_s;
  logic           ovf_r, err_r, last_r;

  logic           accept_s, underflow_s, full_s, drop_s, mul_start_s;
  logic [IW-1:0]  top_idx_s, sec_idx_s, push_idx_s;
  logic [N-1:0]   a_s, b_s, sum_s, diff_s;
  logic           add_ovf_s, sub_ovf_s, mul_ovf_chk_s;
  logic           wr_push_s, wr_top_s, wr_sec_s, ovf_set_s;
  logic [N-1:0]   push_val_s, top_val_s, sec_val_s;

  logic           mul_busy_s, mul_done_s, mul_ovf_s;
  logic [2*N-1:0] mul_product_s;

  seq_signed_mul #(.N(N)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (mul_start_s),
    .a        (a_s),
    .b        (b_s),
    .busy     (mul_busy_s),
    .done     (mul_done_s),
    .product  (mul_product_s),
    .overflow (mul_ovf_s)
  );

  // Token decode, operand fetch and arithmetic; A sits at depth-1, B below it.
  always_comb begin
    accept_s    = in_valid && (state_r == ST_ACCEPT);
    underflow_s = accept_s && (DW'(operands_needed(in_opcode)) > depth_r);
    full_s      = accept_s && grows_stack(in_opcode) && (depth_r == DW'(STACK_SIZE));
    drop_s      = underflow_s || full_s;
    mul_start_s = accept_s && !drop_s && (in_opcode == OP_MUL);
    top_idx_s   = IW'(depth_r - DW'(1));
    sec_idx_s   = IW'(depth_r - DW'(2));
    push_idx_s  = IW'(depth_r);
    a_s         = stack_r[top_idx_s];
    b_s         = stack_r[sec_idx_s];
    sum_s       = b_s + a_s;
    diff_s      = b_s - a_s;
    add_ovf_s   = (b_s[N-1] == a_s[N-1]) && (sum_s[N-1] != b_s[N-1]);
    sub_ovf_s   = (b_s[N-1] != a_s[N-1]) && (diff_s[N-1] != b_s[N-1]);
    // Independent re-check of the product's upper half against the multiplier flag.
    mul_ovf_chk_s = ~((&mul_product_s[2*N-1:N-1]) | ~(|mul_product_s[2*N-1:N-1]));
  end

  // Stack update plan: which slots are written and the resulting depth.
  always_comb begin
    depth_nxt_s = depth_r;
    wr_push_s   = 1'b0;
    wr_top_s    = 1'b0;
    wr_sec_s    = 1'b0;
    push_val_s  = in_data;
    top_val_s   = b_s;
    sec_val_s   = a_s;
    ovf_set_s   = 1'b0;
    case (state_r)
      ST_ACCEPT: begin
        if (accept_s && !drop_s) begin
          case (in_opcode)
            OP_PUSH: begin
              wr_push_s   = 1'b1;
              depth_nxt_s = depth_r + DW'(1);
            end
            OP_DUP: begin
              wr_push_s   = 1'b1;
              push_val_s  = a_s;
              depth_nxt_s = depth_r + DW'(1);
            end
            OP_POP: depth_nxt_s = depth_r - DW'(1);
            OP_SWAP: begin
              wr_top_s = 1'b1;
              wr_sec_s = 1'b1;
            end
            OP_ADD: begin
              wr_sec_s    = 1'b1;
              sec_val_s   = sum_s;
              depth_nxt_s = depth_r - DW'(1);
              ovf_set_s   = add_ovf_s;
            end
            OP_SUB: begin
              wr_sec_s    = 1'b1;
              sec_val_s   = diff_s;
              depth_nxt_s = depth_r - DW'(1);
              ovf_set_s   = sub_ovf_s;
            end
            default: depth_nxt_s = depth_r;  // MUL completes later; NOP does nothing
          endcase
        end else begin
          depth_nxt_s = depth_r;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          wr_sec_s    = 1'b1;
          sec_val_s   = mul_product_s[N-1:0];
          depth_nxt_s = depth_r - DW'(1);
          ovf_set_s   = mul_ovf_s | mul_ovf_chk_s;
        end else begin
          depth_nxt_s = depth_r;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          depth_nxt_s = {DW{1'b0}};
        end else begin
          depth_nxt_s = depth_r;
        end
      end
      default: depth_nxt_s = {DW{1'b0}};
    endcase
  end

  // Stack storage; contents are don't-care after reset, only depth_r matters.
  always_ff @(posedge clk) begin
    if (wr_push_s) stack_r[push_idx_s] <= push_val_s;
    if (wr_top_s)  stack_r[top_idx_s]  <= top_val_s;
    if (wr_sec_s)  stack_r[sec_idx_s]  <= sec_val_s;
  end

  // Depth counter, sticky flags and the deferred in_last of a running MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_r <= {DW{1'b0}};
      ovf_r   <= 1'b0;
      err_r   <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      depth_r <= depth_nxt_s;
      if ((state_r == ST_EMIT) && out_ready) begin
        ovf_r <= 1'b0;
        err_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r | ovf_set_s;
        err_r <= err_r | drop_s;
      end
      if (mul_start_s) last_r <= in_last;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_ACCEPT;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic; a dropped last token still ends the expression.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCEPT: begin
        if (mul_start_s)               state_nxt_s = ST_MUL;
        else if (accept_s && in_last)  state_nxt_s = ST_EMIT;
        else                           state_nxt_s = ST_ACCEPT;
      end
      ST_MUL: begin
        if (mul_done_s)       state_nxt_s = last_r ? ST_EMIT : ST_ACCEPT;
        else if (!mul_busy_s) state_nxt_s = ST_ACCEPT;  // multiplier lost its job: recover
        else                  state_nxt_s = ST_MUL;
      end
      ST_EMIT: begin
        if (out_ready) state_nxt_s = ST_ACCEPT;
        else           state_nxt_s = ST_EMIT;
      end
      default: state_nxt_s = ST_ACCEPT;
    endcase
  end

  // Outputs, all derived from registered state so they hold during EMIT.
  always_comb begin
    in_ready     = (state_r == ST_ACCEPT);
    out_valid    = (state_r == ST_EMIT);
    out_overflow = ovf_r;
    out_error    = err_r | (out_valid && (depth_r != DW'(1)));
    depth        = depth_r;
    if (out_valid && (depth_r != {DW{1'b0}})) out_data = a_s;
    else                                      out_data = {N{1'b0}};
  end

endmodule

// File: tb/tb_rpn_stack_engine.sv
module tb_rpn_stack_engine;
  import rpn_pkg::*;

  localparam int N  = 16;
  localparam int SS = 16;
  localparam int DW = $clog2(SS + 1);

  logic          clk = 1'b0;
  logic          rst, in_valid, in_last, out_ready;
  logic          in_ready, out_valid, out_overflow, out_error;
  logic [2:0]    in_opcode;
  logic [N-1:0]  in_data, out_data;
  logic [DW-1:0] depth;

  rpn_stack_engine #(.N(N), .STACK_SIZE(SS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_error(out_error), .depth(depth)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    op;
    logic [N-1:0]  data;
    logic          last;
    logic [N-1:0]  exp_data;
    logic          exp_ovf;
    logic          exp_err;
    logic [DW-1:0] exp_depth;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void tok(input logic [2:0] op, input logic [N-1:0] d);
    vq.push_back('{op, d, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0});
  endfunction

  function automatic void fin(input logic [2:0] op, input logic [N-1:0] d, input logic [N-1:0] ed,
                              input logic eo, input logic ee, input logic [DW-1:0] edp);
    vq.push_back('{op, d, 1'b1, ed, eo, ee, edp});
  endfunction

  // Present one token and hold it until accepted (bounded).
  task automatic send(input logic [2:0] op, input logic [N-1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_opcode = op; in_data = d; in_last = last;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_opcode = OP_NOP; in_data = 16'h0000;
  endtask

  // Wait for the result, optionally hold it with out_ready low, then handshake.
  task automatic wait_emit(input string tag, input logic [N-1:0] ed, input logic eo,
                           input logic ee, input logic [DW-1:0] edp, input int hold);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " out_data"}, out_data, ed);
    chk({tag, " out_overflow"}, out_overflow, eo);
    chk({tag, " out_error"}, out_error, ee);
    chk({tag, " depth"}, depth, edp);
    chk({tag, " in_ready emit"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_opcode = OP_PUSH; in_data = 16'h5555;
      @(posedge clk); #1;
      chk({tag, " hold data"}, out_data, ed);
      chk({tag, " hold flags"}, {out_valid, in_ready, out_overflow, out_error}, {1'b1, 1'b0, eo, ee});
      chk({tag, " hold depth"}, depth, edp);
    end
    in_valid = 1'b0; in_opcode = OP_NOP;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " post depth"}, depth, 0);
    chk({tag, " post state"}, {in_ready, out_valid, out_overflow, out_error}, 4'b1000);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_opcode = OP_NOP; in_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset depth", depth, 0);
    chk("reset handshake", {in_ready, out_valid}, 2'b10);
    chk("reset out_data", out_data, 0);
    chk("reset flags", {out_overflow, out_error}, 2'b00);
    rst = 1'b0;

    // Mixed expression with two MULs: 6 + (17 * -20) = -334
    tok(OP_PUSH, 16'd2); tok(OP_PUSH, 16'd3); tok(OP_MUL, 16'd0);
    tok(OP_PUSH, 16'd10); tok(OP_PUSH, 16'd4); tok(OP_ADD, 16'd0);
    tok(OP_PUSH, 16'd3); tok(OP_ADD, 16'd0); tok(OP_PUSH, 16'hFFEC);
    tok(OP_MUL, 16'd0); fin(OP_ADD, 16'd0, 16'hFEB2, 1'b0, 1'b0, 5'd1);
    // ADD overflow, then MUL overflow with zero low half
    tok(OP_PUSH, 16'h7FFF); tok(OP_PUSH, 16'h0001);
    fin(OP_ADD, 16'd0, 16'h8000, 1'b1, 1'b0, 5'd1);
    tok(OP_PUSH, 16'h0100); tok(OP_PUSH, 16'h0100);
    fin(OP_MUL, 16'd0, 16'h0000, 1'b1, 1'b0, 5'd1);
    // Underflow, then flags cleared for the next expression
    tok(OP_PUSH, 16'd5); fin(OP_ADD, 16'd0, 16'd5, 1'b0, 1'b1, 5'd1);
    fin(OP_PUSH, 16'd7, 16'd7, 1'b0, 1'b0, 5'd1);
    // Full stack: 17th push dropped
    for (int i = 1; i <= 16; i++) tok(OP_PUSH, 16'h1000 + 16'(i));
    fin(OP_PUSH, 16'hDEAD, 16'h1010, 1'b0, 1'b1, 5'd16);
    // Empty-stack underflows and plain POP/NOP
    fin(OP_POP, 16'd0, 16'h0000, 1'b0, 1'b1, 5'd0);
    fin(OP_DUP, 16'd0, 16'h0000, 1'b0, 1'b1, 5'd0);
    tok(OP_PUSH, 16'd1); tok(OP_PUSH, 16'd2); tok(OP_POP, 16'd0);
    fin(OP_NOP, 16'd0, 16'd1, 1'b0, 1'b0, 5'd1);
    // SUB overflow: -32768 - 1
    tok(OP_PUSH, 16'h8000); tok(OP_PUSH, 16'h0001);
    fin(OP_SUB, 16'd0, 16'h7FFF, 1'b1, 1'b0, 5'd1);
    // Signed MULs: -3 * -7 = 21; -32768 * -1 overflows to 0x8000
    tok(OP_PUSH, 16'hFFFD); tok(OP_PUSH, 16'hFFF9);
    fin(OP_MUL, 16'd0, 16'h0015, 1'b0, 1'b0, 5'd1);
    tok(OP_PUSH, 16'h8000); tok(OP_PUSH, 16'hFFFF);
    fin(OP_MUL, 16'd0, 16'h8000, 1'b1, 1'b0, 5'd1);

    foreach (vq[k]) begin
      send(vq[k].op, vq[k].data, vq[k].last);
      if (vq[k].last) begin
        wait_emit($sformatf("vec%0d", k), vq[k].exp_data, vq[k].exp_ovf,
                  vq[k].exp_err, vq[k].exp_depth, 0);
      end else if (vq[k].op == OP_MUL) begin
        n = 0;
        while (!in_ready && n < 100) begin
          @(posedge clk); #1; n++;
        end
        chk($sformatf("vec%0d mul stall", k), n, 16);
      end
    end

    // SWAP/SUB/DUP expression with the result held for 5 cycles
    send(OP_PUSH, 16'd9, 1'b0);
    send(OP_PUSH, 16'd4, 1'b0);
    send(OP_SWAP, 16'd0, 1'b0);
    send(OP_SUB, 16'd0, 1'b0);
    send(OP_DUP, 16'd0, 1'b0);
    send(OP_ADD, 16'd0, 1'b1);
    wait_emit("hold", 16'hFFF6, 1'b0, 1'b0, 5'd1, 5);

    // Reset in the middle of a MUL aborts it without emitting
    send(OP_PUSH, 16'd3, 1'b0);
    send(OP_PUSH, 16'd5, 1'b0);
    send(OP_MUL, 16'd0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    chk("mid-mul busy", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort depth", depth, 0);
    chk("abort state", {in_ready, out_valid, out_overflow, out_error}, 4'b1000);
    repeat (20) @(posedge clk);
    #1;
    chk("abort no emit", {out_valid, depth}, 0);
    send(OP_PUSH, 16'd6, 1'b0);
    send(OP_PUSH, 16'hFFF9, 1'b0);
    send(OP_MUL, 16'd0, 1'b1);
    wait_emit("after abort", 16'hFFD6, 1'b0, 1'b0, 5'd1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
